// File: rtl/axi_w_burst_pkg.sv
// Shared types and sizing for the AXI W-channel burst generator.
// XLEN follows the prv664 core width. No ports (package only).
package axi_w_burst_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned LINE_BEATS = 8;
  localparam int unsigned STRB_W     = XLEN / 8;
  localparam int unsigned LINE_BITS  = XLEN * LINE_BEATS;
  localparam int unsigned STRB_BITS  = LINE_BEATS * 8;
  localparam int unsigned CNT_W      = $clog2(LINE_BEATS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Line viewed as an array of beats so beat k is a simple index.
  typedef logic [LINE_BEATS-1:0][XLEN-1:0]   line_t;
  typedef logic [LINE_BEATS-1:0][STRB_W-1:0] strb_line_t;

  // Captured write-back request.
  typedef struct packed {
    line_t            data;
    strb_line_t       strb;
    logic [CNT_W-1:0] len;
  } req_t;

endpackage

// File: rtl/axi_w_burst_gen.sv
// Write-data burst generator for the AXI W channel.
// Latches one cache line plus byte mask from the writeback path and emits
// it as XLEN-wide beats with wstrb/wlast. AW is issued elsewhere.
//
// Ports:
//   clk_i, arst_n_i          clock, async active-low reset
//   req_valid_i/req_ready_o  upstream line request handshake
//   req_data_i               line data, beat k = [k*XLEN +: XLEN]
//   req_strb_i               byte mask, beat k = [k*8 +: 8]
//   req_len_i                beats minus one
//   wdata_o/wstrb_o/wlast_o  W payload
//   wvalid_o/wready_i        W handshake
//   done_o                   pulse on the cycle the last beat transfers
//
// Config macro AXI_W_BURST_B2B_EN: when defined, a new request may be
// accepted on the last-beat transfer so bursts run with no bubble.
module axi_w_burst_gen
  import axi_w_burst_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [LINE_BITS-1:0] req_data_i,
  input  logic [STRB_BITS-1:0] req_strb_i,
  input  logic [CNT_W-1:0]     req_len_i,
  output logic [XLEN-1:0]      wdata_o,
  output logic [STRB_W-1:0]    wstrb_o,
  output logic                 wlast_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  output logic                 done_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             last_beat;
  req_t             req_in;

  assign last_beat  = (cnt_q == req_q.len);
  assign req_in     = '{data: line_t'(req_data_i),
                        strb: strb_line_t'(req_strb_i),
                        len:  req_len_i};

  // State, beat counter and captured line.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state, counter advance and W outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_o = 1'b0;
    wvalid_o    = 1'b0;
    wdata_o     = '0;
    wstrb_o     = '0;
    wlast_o     = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          req_d   = req_in;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        wvalid_o = 1'b1;
        wdata_o  = req_q.data[cnt_q];
        wstrb_o  = req_q.strb[cnt_q];
        wlast_o  = last_beat;
        if (wready_i) begin
          if (last_beat) begin
            done_o  = 1'b1;
            state_d = IDLE;
`ifdef AXI_W_BURST_B2B_EN
            // Accept the next line on the final transfer to avoid a bubble.
            req_ready_o = 1'b1;
            if (req_valid_i) begin
              req_d   = req_in;
              cnt_d   = '0;
              state_d = SEND;
            end
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_w_burst_gen.sv
// Directed self-checking bench for axi_w_burst_gen.
module tb_axi_w_burst_gen;
  import axi_w_burst_pkg::*;

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [LINE_BITS-1:0] req_data;
  logic [STRB_BITS-1:0] req_strb;
  logic [CNT_W-1:0]     req_len;
  logic [XLEN-1:0]      wdata;
  logic [STRB_W-1:0]    wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;
  logic                 done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_w_burst_gen dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_strb_i  (req_strb),
    .req_len_i   (req_len),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .wlast_o     (wlast),
    .wvalid_o    (wvalid),
    .wready_i    (wready),
    .done_o      (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Line whose beat k holds base + k.
  function automatic logic [LINE_BITS-1:0] mk_line(input logic [63:0] base);
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < int'(LINE_BEATS); k++) l[k*XLEN +: XLEN] = XLEN'(base) + XLEN'(k);
    return l;
  endfunction

  task automatic test_reset();
    arst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_strb = '0; req_len = '0; wready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid got=%b want=0", wvalid); end
    total++; if (wlast !== 1'b0) begin bad++; $display("FAIL reset_wlast got=%b want=0", wlast); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (wdata !== '0 || wstrb !== '0) begin bad++; $display("FAIL reset_payload data=%h strb=%h want 0", wdata, wstrb); end
    arst_n = 1'b1;
    cyc();
    total++; if (req_ready !== 1'b1 || wvalid !== 1'b0) begin bad++; $display("FAIL post_reset ready=%b valid=%b want 1/0", req_ready, wvalid); end
  endtask

  task automatic test_full_burst();
    logic [63:0] exp;
    cyc();
    req_valid = 1'b1; req_len = 3'd7; req_data = mk_line(64'h1111_0000_0000_0000); req_strb = '1; wready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1 || wvalid !== 1'b0) begin bad++; $display("FAIL full_hs ready=%b valid=%b want 1/0", req_ready, wvalid); end
    cyc();
    // Changing request inputs after capture must not matter.
    req_valid = 1'b0; req_data = '1; req_strb = '0; req_len = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = 64'h1111_0000_0000_0000 + 64'(k);
      total++; if (wvalid !== 1'b1) begin bad++; $display("FAIL full_valid beat=%0d got=%b want=1", k, wvalid); end
      total++; if (wdata !== exp) begin bad++; $display("FAIL full_data beat=%0d got=%h want=%h", k, wdata, exp); end
      total++; if (wstrb !== 8'hFF) begin bad++; $display("FAIL full_strb beat=%0d got=%h want=ff", k, wstrb); end
      total++; if (wlast !== (k == 7)) begin bad++; $display("FAIL full_last beat=%0d got=%b want=%b", k, wlast, (k == 7)); end
      total++; if (done !== (k == 7)) begin bad++; $display("FAIL full_done beat=%0d got=%b want=%b", k, done, (k == 7)); end
      total++; if (req_ready !== (k == 7 && `ifdef AXI_W_BURST_B2B_EN 1'b1 `else 1'b0 `endif)) begin
        bad++; $display("FAIL full_ready_in_send beat=%0d got=%b", k, req_ready);
      end
      cyc();
    end
    #1;
    total++; if (wvalid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL full_end valid=%b ready=%b want 0/1", wvalid, req_ready); end
  endtask

  task automatic test_backpressure();
    logic        pat [7];
    logic [63:0] exp;
    logic [7:0]  exps;
    int          k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    k = 0;
    cyc();
    req_valid = 1'b1; req_len = 3'd3; req_data = mk_line(64'h2222_0000_0000_0000);
    for (int b = 0; b < 8; b++) req_strb[b*8 +: 8] = 8'(17 * (b + 1));
    wready = 1'b0;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wready = pat[i];
      #1;
      exp  = 64'h2222_0000_0000_0000 + 64'(k);
      exps = 8'(17 * (k + 1));
      total++; if (wvalid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, wvalid); end
      total++; if (wdata !== exp || wstrb !== exps) begin bad++; $display("FAIL bp_payload cyc=%0d data=%h strb=%h want %h/%h", i, wdata, wstrb, exp, exps); end
      total++; if (wlast !== (k == 3)) begin bad++; $display("FAIL bp_last cyc=%0d got=%b want=%b", i, wlast, (k == 3)); end
      total++; if (done !== (pat[i] && k == 3)) begin bad++; $display("FAIL bp_done cyc=%0d got=%b want=%b", i, done, (pat[i] && k == 3)); end
      if (pat[i]) k++;
      cyc();
    end
    wready = 1'b1;
    #1;
    total++; if (wvalid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_end valid=%b ready=%b want 0/1", wvalid, req_ready); end
  endtask

  task automatic test_single_beat();
    cyc();
    req_valid = 1'b1; req_len = 3'd0; req_data = mk_line(64'h3333_0000_0000_0000);
    req_strb = '1; req_strb[7:0] = 8'h0F; wready = 1'b1;
    cyc();
    req_valid = 1'b0;
    #1;
    total++; if (wvalid !== 1'b1 || wlast !== 1'b1) begin bad++; $display("FAIL single_vl valid=%b last=%b want 1/1", wvalid, wlast); end
    total++; if (wstrb !== 8'h0F) begin bad++; $display("FAIL single_strb got=%h want=0f", wstrb); end
    total++; if (wdata !== 64'h3333_0000_0000_0000) begin bad++; $display("FAIL single_data got=%h want=3333000000000000", wdata); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", done); end
    cyc();
    #1;
    total++; if (wvalid !== 1'b0 || wlast !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL single_idle valid=%b last=%b ready=%b want 0/0/1", wvalid, wlast, req_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] exp;
    cyc();
    req_valid = 1'b1; req_len = 3'd7; req_data = mk_line(64'h4444_0000_0000_0000); req_strb = '1; wready = 1'b1;
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    #1;
    total++; if (wvalid !== 1'b1 || wdata !== 64'h4444_0000_0000_0003) begin
      bad++; $display("FAIL midrst_pre valid=%b data=%h want 1/4444000000000003", wvalid, wdata);
    end
    arst_n = 1'b0;
    #1;
    total++; if (wvalid !== 1'b0 || wlast !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_async valid=%b last=%b done=%b want 0/0/0", wvalid, wlast, done);
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", req_ready); end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    cyc();
    req_valid = 1'b1; req_len = 3'd1; req_data = mk_line(64'h5555_0000_0000_0000);
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp = 64'h5555_0000_0000_0000 + 64'(k);
      total++; if (wvalid !== 1'b1 || wdata !== exp) begin bad++; $display("FAIL midrst_new beat=%0d valid=%b data=%h want 1/%h", k, wvalid, wdata, exp); end
      total++; if (wlast !== (k == 1) || done !== (k == 1)) begin bad++; $display("FAIL midrst_last beat=%0d last=%b done=%b", k, wlast, done); end
      cyc();
    end
    #1;
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL midrst_end valid=%b want=0", wvalid); end
  endtask

  task automatic test_back_to_back();
    cyc();
    req_valid = 1'b1; req_len = 3'd1; req_data = mk_line(64'h6666_0000_0000_0000); req_strb = '1; wready = 1'b1;
    cyc();
    req_valid = 1'b0;
    #1;
    total++; if (wvalid !== 1'b1 || wdata !== 64'h6666_0000_0000_0000 || wlast !== 1'b0) begin
      bad++; $display("FAIL b2b_a0 valid=%b data=%h last=%b", wvalid, wdata, wlast);
    end
    cyc();
    req_valid = 1'b1; req_data = mk_line(64'h7777_0000_0000_0000);
    #1;
    total++; if (wdata !== 64'h6666_0000_0000_0001 || wlast !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL b2b_a1 data=%h last=%b done=%b", wdata, wlast, done);
    end
`ifdef AXI_W_BURST_B2B_EN
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_on_last got=%b want=1", req_ready); end
    cyc();
    req_valid = 1'b0;
`else
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_on_last got=%b want=0", req_ready); end
    cyc();
    #1;
    total++; if (wvalid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle valid=%b ready=%b want 0/1", wvalid, req_ready); end
    cyc();
    req_valid = 1'b0;
`endif
    #1;
    total++; if (wvalid !== 1'b1 || wdata !== 64'h7777_0000_0000_0000 || wlast !== 1'b0) begin
      bad++; $display("FAIL b2b_b0 valid=%b data=%h last=%b", wvalid, wdata, wlast);
    end
    cyc();
    #1;
    total++; if (wvalid !== 1'b1 || wdata !== 64'h7777_0000_0000_0001 || wlast !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL b2b_b1 valid=%b data=%h last=%b done=%b", wvalid, wdata, wlast, done);
    end
    cyc();
    #1;
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL b2b_end valid=%b want=0", wvalid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_single_beat();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
